// File: rtl/col_reorder_buffer.sv
// Inverse-permutes one frame of back-substitution symbols into original column order.
// Two ping-pong banks let a new frame stream in while the previous one drains.
module col_reorder_buffer #(
  parameter int unsigned SYM_WL = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [23:0]           order_i,
  input  logic [SYM_WL-1:0]     sym_i,
  input  logic                  sym_valid_i,
  output logic                  sym_ready_o,
  output logic [8*SYM_WL-1:0]   vec_o,
  output logic                  vec_valid_o,
  input  logic                  vec_ready_i,
  output logic                  dup_err_o
);

  logic              wb_q, wb_d, rb_q, rb_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [23:0]       order_q, order_d;
  logic [SYM_WL-1:0] data_q [2][8];
  logic [SYM_WL-1:0] data_d [2][8];
  logic [7:0]        wr_q [2];
  logic [7:0]        wr_d [2];
  logic [1:0]        dup_q, dup_d, full_q, full_d;

  logic        accept, drain;
  logic [23:0] cur_order;
  logic [4:0]  base;
  logic [2:0]  idx;

  assign accept = sym_valid_i & ~full_q[wb_q];
  assign drain  = full_q[rb_q] & vec_ready_i;

  // The first symbol of a frame uses order_i directly; the rest use the latched copy.
  assign cur_order = (cnt_q == 3'd7) ? order_i : order_q;
  assign base      = 5'(cnt_q) * 5'd3;
  assign idx       = cur_order[base +: 3];

  assign sym_ready_o = ~full_q[wb_q];
  assign vec_valid_o = full_q[rb_q];
  assign dup_err_o   = dup_q[rb_q];

  always_comb begin
    vec_o = '0;
    for (int j = 0; j < 8; j++) begin
      if (wr_q[rb_q][j]) vec_o[j*SYM_WL +: SYM_WL] = data_q[rb_q][j];
    end
  end

  always_comb begin
    wb_d    = wb_q;
    rb_d    = rb_q;
    cnt_d   = cnt_q;
    order_d = order_q;
    data_d  = data_q;
    wr_d    = wr_q;
    dup_d   = dup_q;
    full_d  = full_q;

    if (accept) begin
      if (cnt_q == 3'd7) order_d = order_i;
      data_d[wb_q][idx] = sym_i;
      wr_d[wb_q][idx]   = 1'b1;
      if (wr_q[wb_q][idx]) dup_d[wb_q] = 1'b1;
      if (cnt_q == 3'd0) begin
        full_d[wb_q] = 1'b1;
        wb_d         = ~wb_q;
        cnt_d        = 3'd7;
      end else begin
        cnt_d = cnt_q - 3'd1;
      end
    end

    // Never the bank being written: that one is not full.
    if (drain) begin
      for (int j = 0; j < 8; j++) data_d[rb_q][j] = '0;
      wr_d[rb_q]   = '0;
      dup_d[rb_q]  = 1'b0;
      full_d[rb_q] = 1'b0;
      rb_d         = ~rb_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_q    <= 1'b0;
      rb_q    <= 1'b0;
      cnt_q   <= 3'd7;
      order_q <= '0;
      for (int b = 0; b < 2; b++) begin
        for (int j = 0; j < 8; j++) data_q[b][j] <= '0;
        wr_q[b] <= '0;
      end
      dup_q  <= '0;
      full_q <= '0;
    end else begin
      wb_q    <= wb_d;
      rb_q    <= rb_d;
      cnt_q   <= cnt_d;
      order_q <= order_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      dup_q   <= dup_d;
      full_q  <= full_d;
    end
  end

endmodule

// File: tb/tb_col_reorder_buffer.sv
// Randomized bench for col_reorder_buffer against a frame-level reference model,
// plus hand-computed vectors for identity, reverse, duplicate and reset cases.
module tb_col_reorder_buffer;

  localparam int unsigned W = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [23:0]     order_i = '0;
  logic [W-1:0]    sym_i = '0;
  logic            sym_valid_i = 1'b0;
  logic            sym_ready_o;
  logic [8*W-1:0]  vec_o;
  logic            vec_valid_o;
  logic            vec_ready_i;
  logic            dup_err_o;

  logic dir_rdy = 1'b0;
  logic rnd_en = 1'b0;
  logic rnd_bit = 1'b0;
  assign vec_ready_i = rnd_en ? rnd_bit : dir_rdy;

  col_reorder_buffer #(.SYM_WL(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .order_i     (order_i),
    .sym_i       (sym_i),
    .sym_valid_i (sym_valid_i),
    .sym_ready_o (sym_ready_o),
    .vec_o       (vec_o),
    .vec_valid_o (vec_valid_o),
    .vec_ready_i (vec_ready_i),
    .dup_err_o   (dup_err_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rnd_bit <= 1'($urandom_range(0, 1));

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of completed frames awaiting drain, plus the frame being collected.
  typedef struct packed {
    logic [8*W-1:0] vec;
    logic           dup;
  } frame_t;

  frame_t      pend[$];
  int          m_cnt = 7;
  logic [23:0] m_ord = '0;
  logic [W-1:0] m_sym [8];
  frame_t      m_f;
  logic [7:0]  m_seen;
  int          m_o;
  bit          m_acc, m_drn;

  always @(negedge clk) begin
    if (!rst_n) begin
      pend.delete();
      m_cnt = 7;
    end else begin
      chk("sym_ready", sym_ready_o, 64'(pend.size() < 2));
      chk("vec_valid", vec_valid_o, 64'(pend.size() > 0));
      if (pend.size() > 0) begin
        chk("vec", vec_o, 64'(pend[0].vec));
        chk("dup_err", dup_err_o, 64'(pend[0].dup));
      end
      m_acc = sym_valid_i && (pend.size() < 2);
      m_drn = (pend.size() > 0) && vec_ready_i;
      if (m_drn) void'(pend.pop_front());
      if (m_acc) begin
        if (m_cnt == 7) m_ord = order_i;
        m_sym[m_cnt] = sym_i;
        if (m_cnt == 0) begin
          // Scatter in arrival order (k=7..0) so later writes win; dup if any index repeats.
          m_f    = '0;
          m_seen = '0;
          for (int k = 7; k >= 0; k--) begin
            m_o = int'(m_ord[3*k +: 3]);
            if (m_seen[m_o]) m_f.dup = 1'b1;
            m_seen[m_o] = 1'b1;
            m_f.vec[m_o*W +: W] = m_sym[k];
          end
          pend.push_back(m_f);
          m_cnt = 7;
        end else begin
          m_cnt--;
        end
      end
    end
  end

  task automatic push(input logic [W-1:0] s, input logic [23:0] o);
    sym_i = s;
    order_i = o;
    sym_valid_i = 1'b1;
    for (int t = 0; ; t++) begin
      @(negedge clk);
      if (sym_ready_o) break;
      if (t > 200) begin
        chk("push_timeout", 64'd0, 64'd1);
        sym_valid_i = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    sym_valid_i = 1'b0;
  endtask

  // syms holds the symbol for permuted column k in bits [2k+1:2k].
  task automatic send_frame(input logic [15:0] syms, input logic [23:0] o);
    for (int k = 7; k >= 0; k--) push(syms[2*k +: 2], o);
  endtask

  task automatic drain_one();
    dir_rdy = 1'b1;
    @(posedge clk);
    #1;
    dir_rdy = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  localparam logic [23:0] OrdIdent = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
  localparam logic [23:0] OrdRev   = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
  localparam logic [23:0] OrdDup   = {3'd7, 3'd6, 3'd4, 3'd3, 3'd2, 3'd1, 3'd5, 3'd5};

  function automatic logic [23:0] rot_order(input int r);
    logic [23:0] o;
    for (int k = 0; k < 8; k++) o[3*k +: 3] = 3'((k + r) % 8);
    return o;
  endfunction

  initial begin
    logic [15:0] rs;
    logic [23:0] ro;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", sym_ready_o, 1);
    chk("reset_valid", vec_valid_o, 0);
    chk("reset_vec", vec_o, 0);
    chk("reset_dup", dup_err_o, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    send_frame(16'hE4E4, OrdIdent);
    chk("ident_latency", vec_valid_o, 1);
    chk("ident_vec", vec_o, 16'hE4E4);
    chk("ident_dup", dup_err_o, 0);
    drain_one();

    send_frame(16'h1B1B, OrdRev);
    chk("rev_vec", vec_o, 16'hE4E4);
    chk("rev_dup", dup_err_o, 0);
    drain_one();

    send_frame(16'h6DB6, OrdDup);
    chk("dup_vec", vec_o, 16'h6B6C);
    chk("dup_flag", dup_err_o, 1);
    drain_one();

    // Two frames fill both banks; the third stalls until the first drain.
    for (int f = 0; f < 2; f++) send_frame(16'($urandom), rot_order(f + 1));
    repeat (3) @(negedge clk);
    chk("full_ready_low", sym_ready_o, 0);
    fork
      send_frame(16'($urandom), rot_order(5));
      begin
        @(posedge clk);
        #1;
        dir_rdy = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_drain", sym_ready_o, 1);
      end
    join
    repeat (30) @(posedge clk);
    chk("btb_drained", vec_valid_o, 0);
    dir_rdy = 1'b0;

    // Gappy input, random drain, order_i changing between accepts.
    rnd_en = 1'b1;
    for (int f = 0; f < 24; f++) begin
      for (int k = 7; k >= 0; k--) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
        ro = ($urandom_range(0, 1) == 1) ? rot_order(int'($urandom_range(0, 7))) : 24'($urandom);
        push(2'($urandom), ro);
      end
    end
    rnd_en = 1'b0;
    dir_rdy = 1'b1;
    for (int t = 0; t < 50 && pend.size() > 0; t++) @(posedge clk);
    chk("final_drain", 64'(pend.size()), 0);

    // Partial frame discarded by reset.
    for (int k = 0; k < 4; k++) push(2'($urandom), OrdIdent);
    pulse_reset();
    chk("rst_valid", vec_valid_o, 0);
    chk("rst_ready", sym_ready_o, 1);
    dir_rdy = 1'b0;
    send_frame(16'hE4E4, OrdIdent);
    chk("post_rst_vec", vec_o, 16'hE4E4);
    chk("post_rst_dup", dup_err_o, 0);
    drain_one();
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/col_reorder_buffer.md
# col_reorder_buffer

Restores original antenna/column order of detected real-valued symbols after sorted-QR detection. The column-exchange stages permute the 8 real columns of H and carry a 3-bit original-index tag per column (colorder). The back-substitution detector emits symbols in that permuted order. This block applies the inverse permutation and presents one complete 8-symbol vector per frame. It uses two ping-pong banks so that input streaming and output draining overlap.

## Interface
- SYM_WL, 2: bits per detected real symbol (two's-complement or level index; opaque to this block).
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- order_i  in  24  final colorder; field k = bits [3k+2:3k] = original column index of permuted column k. Sampled only on the first accepted symbol of a frame.
- sym_i  in  SYM_WL  detected symbol of the current permuted column.
- sym_valid_i  in  1  sym_i valid.
- sym_ready_o  out  1  block can accept sym_i this cycle.
- vec_o  out  8*SYM_WL  reordered vector; field j = bits [j*SYM_WL+SYM_WL-1 : j*SYM_WL] = symbol of original column j.
- vec_valid_o  out  1  vec_o and dup_err_o valid.
- vec_ready_i  in  1  consumer accepts vec_o.
- dup_err_o  out  1  the delivered frame's order_i was not a permutation (some original index written twice).

## Operation
- Frame = 8 accepted symbols in back-substitution order: permuted column k = 7, 6, …, 0. Accept = sym_valid_i && sym_ready_o.
- Input counter cnt (3 bits) starts at 7 and decrements per accept. On the accept with cnt==7, order_i is latched into order_q. The latched value is used for that accept and for the rest of the frame.
- Each accept writes sym_i into entry order[cnt] of write bank wb and sets that entry's written bit. If the written bit was already set, the bank's dup flag is set.
- The accept with cnt==0 completes the frame. It marks bank wb full, toggles wb and reloads cnt to 7.
- sym_ready_o = !full[wb].
- Output side: read bank rb. vec_valid_o = full[rb]. vec_o and dup_err_o are driven from bank rb contents. Entries with written bit clear read as 0.
- Output handshake: on vec_valid_o && vec_ready_i, bank rb is cleared (data, written bits, dup, full all 0) and rb toggles.
- vec_o and dup_err_o are held stable while vec_valid_o=1 and vec_ready_i=0.
- No input-side flow control beyond sym_ready_o. sym_i is ignored when not accepted.

## Timing
- Reset (async assert, sync deassert by system): wb=rb=0, cnt=7, both banks cleared, order_q=0. Outputs: sym_ready_o=1, vec_valid_o=0, vec_o=0, dup_err_o=0.
- Latency: 8th accept at edge t makes vec_valid_o=1 after edge t (visible in cycle t+1).
- Throughput: 1 symbol/cycle sustained with vec_ready_i=1. One vector per 8 cycles, no bubbles across frames.
- Both banks full: sym_ready_o=0 until a vector is drained. Ready rises in the cycle after the draining edge.
- Same-cycle final accept into bank A and drain of bank B: both take effect, since the banks are independent.
- Drain and accept never target the same bank in one cycle. A bank being written is never full.
- Reset mid-frame or while vectors are pending: all partial and complete frames are discarded. Nothing is emitted afterwards until 8 new accepts.
- sym_valid_i deasserted mid-frame: cnt and bank state hold. The frame resumes on later accepts. order_q is not re-sampled.

## Test plan
- Identity order (order_i field k = k), symbols for k=7..0 = 3,2,1,0,3,2,1,0 -> vec_o fields j=0..7 = 0,1,2,3,0,1,2,3; dup_err_o=0; vec_valid_o one cycle after 8th accept.
- Reverse order (field k = 7-k), symbols k=7..0 = 0,1,2,3,0,1,2,3 -> field j = symbol of k=7-j = 0,1,2,3,0,1,2,3; dup_err_o=0.
- Back-to-back 3 frames with vec_ready_i held 0 -> sym_ready_o drops after 16 accepts. Raise vec_ready_i -> vectors emerge in frame order with correct contents; ready returns the cycle after the first drain.
- order_i with fields k=0 and k=1 both = 5 -> dup_err_o=1 with that vector. Field of the never-written index = 0. Entry 5 holds the later-written (k=0) symbol.
- Gappy input (valid toggled randomly), with order_i changed between accepts mid-frame -> output uses the order latched at first accept only.
- rst_n pulsed low after 4 accepts -> vec_valid_o=0, sym_ready_o=1; the next full frame reorders correctly with no leftover data.
